// File: rtl/ecdsa_key_store.sv
// rtl/ecdsa_key_store.sv - multi-slot ECDSA key store with range check, per-slot lock and zeroize
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ld_valid/ld_ready               load handshake; ld_slot/ld_priv/ld_pub_x/ld_pub_y/ld_lock captured on accept
//   ld_done/ld_err                  one-cycle completion pulse, error code held until the next completion
//   rd_req/rd_slot                  slot read request
//   rd_valid/rd_err/rd_priv/        one-cycle read response; data is zero unless a valid key is returned
//   rd_pub_x/rd_pub_y
//   zeroize                         clear every slot, aborts any load in flight
//   busy                            load/zeroize FSM not idle
//   slot_valid/slot_locked          per-slot key present / write-locked
module ecdsa_key_store #(
  parameter int KEY_W     = 256,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_AW   = 2,
  parameter logic [KEY_W-1:0] CURVE_N =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [SLOT_AW-1:0]   ld_slot,
  input  logic [KEY_W-1:0]     ld_priv,
  input  logic [KEY_W-1:0]     ld_pub_x,
  input  logic [KEY_W-1:0]     ld_pub_y,
  input  logic                 ld_lock,
  output logic                 ld_done,
  output logic [1:0]           ld_err,
  input  logic                 rd_req,
  input  logic [SLOT_AW-1:0]   rd_slot,
  output logic                 rd_valid,
  output logic [KEY_W-1:0]     rd_priv,
  output logic [KEY_W-1:0]     rd_pub_x,
  output logic [KEY_W-1:0]     rd_pub_y,
  output logic                 rd_err,
  input  logic                 zeroize,
  output logic                 busy,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic [NUM_SLOTS-1:0] slot_locked
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_ZERO} state_t;

  localparam int SLOT_CNT_W = SLOT_AW + 1;
  localparam logic [SLOT_CNT_W-1:0] SLOT_LIMIT = SLOT_CNT_W'(NUM_SLOTS);
  localparam logic [SLOT_AW-1:0]    LAST_SLOT  = SLOT_AW'(NUM_SLOTS - 1);

  state_t               state_q, state_d;
  logic [SLOT_AW-1:0]   zcnt_q, zcnt_d;

  // holding registers for the accepted load request
  logic [SLOT_AW-1:0]   h_slot_q, h_slot_d;
  logic [KEY_W-1:0]     h_priv_q, h_priv_d;
  logic [KEY_W-1:0]     h_x_q, h_x_d;
  logic [KEY_W-1:0]     h_y_q, h_y_d;
  logic                 h_lock_q, h_lock_d;

  logic                 done_q, done_d;
  logic [1:0]           err_q, err_d;

  logic [KEY_W-1:0]     key_priv_q [NUM_SLOTS];
  logic [KEY_W-1:0]     key_priv_d [NUM_SLOTS];
  logic [KEY_W-1:0]     key_x_q [NUM_SLOTS];
  logic [KEY_W-1:0]     key_x_d [NUM_SLOTS];
  logic [KEY_W-1:0]     key_y_q [NUM_SLOTS];
  logic [KEY_W-1:0]     key_y_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [NUM_SLOTS-1:0] locked_q, locked_d;

  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_err_q, rd_err_d;
  logic [KEY_W-1:0]     rd_priv_q, rd_priv_d;
  logic [KEY_W-1:0]     rd_x_q, rd_x_d;
  logic [KEY_W-1:0]     rd_y_q, rd_y_d;

  logic [1:0]           chk_err;
  logic                 h_locked;
  logic                 commit;
  logic                 rd_hit;
  logic                 rd_sel_valid;
  logic [KEY_W-1:0]     rd_sel_priv, rd_sel_x, rd_sel_y;

  // Error code for the held request, highest priority first.
  always_comb begin
    h_locked = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (h_slot_q == SLOT_AW'(k)) h_locked = locked_q[k];
    end
    if ({1'b0, h_slot_q} >= SLOT_LIMIT)                  chk_err = 2'd3;
    else if (h_locked)                                   chk_err = 2'd2;
    else if (h_priv_q == '0 || h_priv_q >= CURVE_N)      chk_err = 2'd1;
    else                                                 chk_err = 2'd0;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      zcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      zcnt_q  <= zcnt_d;
    end
  end

  // FSM next state; zeroize overrides everything and restarts the sweep.
  always_comb begin
    state_d = state_q;
    zcnt_d  = zcnt_q;
    if (zeroize) begin
      state_d = S_ZERO;
      zcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE:  if (ld_valid) state_d = S_CHECK;
        S_CHECK: state_d = (chk_err != 2'd0) ? S_IDLE : S_WRITE;
        S_WRITE: state_d = S_IDLE;
        S_ZERO: begin
          if (zcnt_q == LAST_SLOT) state_d = S_IDLE;
          else                     zcnt_d  = zcnt_q + 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs. A successful load reports completion in its WRITE cycle so
  // that both outcomes complete two cycles after the handshake.
  always_comb begin
    commit   = (state_q == S_WRITE) && !zeroize;
    ld_ready = (state_q == S_IDLE) && !zeroize;
    busy     = (state_q != S_IDLE);
    ld_done  = done_q || commit;
    ld_err   = commit ? 2'd0 : err_q;
  end

  // Load capture, error latch, slot writes and zeroize sweep
  always_comb begin
    h_slot_d   = h_slot_q;
    h_priv_d   = h_priv_q;
    h_x_d      = h_x_q;
    h_y_d      = h_y_q;
    h_lock_d   = h_lock_q;
    done_d     = 1'b0;
    err_d      = err_q;
    key_priv_d = key_priv_q;
    key_x_d    = key_x_q;
    key_y_d    = key_y_q;
    valid_d    = valid_q;
    locked_d   = locked_q;

    if (ld_valid && ld_ready) begin
      h_slot_d = ld_slot;
      h_priv_d = ld_priv;
      h_x_d    = ld_pub_x;
      h_y_d    = ld_pub_y;
      h_lock_d = ld_lock;
    end

    if (state_q == S_CHECK && !zeroize && chk_err != 2'd0) begin
      done_d = 1'b1;
      err_d  = chk_err;
    end

    if (commit) begin
      err_d = 2'd0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (h_slot_q == SLOT_AW'(k)) begin
          key_priv_d[k] = h_priv_q;
          key_x_d[k]    = h_x_q;
          key_y_d[k]    = h_y_q;
          valid_d[k]    = 1'b1;
          if (h_lock_q) locked_d[k] = 1'b1;
        end
      end
    end

    if (state_q == S_ZERO) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (zcnt_q == SLOT_AW'(k)) begin
          key_priv_d[k] = '0;
          key_x_d[k]    = '0;
          key_y_d[k]    = '0;
          valid_d[k]    = 1'b0;
          locked_d[k]   = 1'b0;
        end
      end
    end
  end

  // Read path: sees register contents before this cycle's write; an
  // out-of-range index never matches a slot and so reads as empty.
  always_comb begin
    rd_sel_valid = 1'b0;
    rd_sel_priv  = '0;
    rd_sel_x     = '0;
    rd_sel_y     = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (rd_slot == SLOT_AW'(k)) begin
        rd_sel_valid = valid_q[k];
        rd_sel_priv  = key_priv_q[k];
        rd_sel_x     = key_x_q[k];
        rd_sel_y     = key_y_q[k];
      end
    end
    rd_hit     = rd_req && rd_sel_valid && (state_q != S_ZERO);
    rd_valid_d = rd_req;
    rd_err_d   = rd_req && !rd_hit;
    rd_priv_d  = rd_hit ? rd_sel_priv : '0;
    rd_x_d     = rd_hit ? rd_sel_x : '0;
    rd_y_d     = rd_hit ? rd_sel_y : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_slot_q   <= '0;
      h_priv_q   <= '0;
      h_x_q      <= '0;
      h_y_q      <= '0;
      h_lock_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 2'd0;
      valid_q    <= '0;
      locked_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_priv_q  <= '0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        key_priv_q[k] <= '0;
        key_x_q[k]    <= '0;
        key_y_q[k]    <= '0;
      end
    end else begin
      h_slot_q   <= h_slot_d;
      h_priv_q   <= h_priv_d;
      h_x_q      <= h_x_d;
      h_y_q      <= h_y_d;
      h_lock_q   <= h_lock_d;
      done_q     <= done_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_priv_q  <= rd_priv_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        key_priv_q[k] <= key_priv_d[k];
        key_x_q[k]    <= key_x_d[k];
        key_y_q[k]    <= key_y_d[k];
      end
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_err      = rd_err_q;
  assign rd_priv     = rd_priv_q;
  assign rd_pub_x    = rd_x_q;
  assign rd_pub_y    = rd_y_q;
  assign slot_valid  = valid_q;
  assign slot_locked = locked_q;

endmodule

// File: tb/tb_ecdsa_key_store.sv
// tb/tb_ecdsa_key_store.sv - scoreboard bench for ecdsa_key_store (4-slot and 3-slot instances)
module tb_ecdsa_key_store;

  localparam int KW = 256;
  localparam logic [KW-1:0] CN = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
  localparam logic [KW-1:0] KA = {8{32'hA5A50001}};
  localparam logic [KW-1:0] KB = {8{32'h5A5A0002}};
  localparam logic [KW-1:0] KC = {8{32'h12340003}};
  localparam logic [KW-1:0] KD = {8{32'h43210004}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, ld_valid, ld_lock, rd_req, zeroize;
  logic [1:0]    ld_slot, rd_slot;
  logic [KW-1:0] ld_priv, ld_pub_x, ld_pub_y;

  logic          ld_ready, ld_done, rd_valid, rd_err, busy;
  logic [1:0]    ld_err;
  logic [KW-1:0] rd_priv, rd_pub_x, rd_pub_y;
  logic [3:0]    slot_valid, slot_locked;

  logic          ld_ready3, ld_done3, rd_valid3, rd_err3, busy3;
  logic [1:0]    ld_err3;
  logic [KW-1:0] rd_priv3, rd_pub_x3, rd_pub_y3;
  logic [2:0]    slot_valid3, slot_locked3;

  ecdsa_key_store #(.KEY_W(KW), .NUM_SLOTS(4), .SLOT_AW(2), .CURVE_N(CN)) u_dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_slot(ld_slot),
    .ld_priv(ld_priv), .ld_pub_x(ld_pub_x), .ld_pub_y(ld_pub_y), .ld_lock(ld_lock),
    .ld_done(ld_done), .ld_err(ld_err), .rd_req(rd_req), .rd_slot(rd_slot),
    .rd_valid(rd_valid), .rd_priv(rd_priv), .rd_pub_x(rd_pub_x), .rd_pub_y(rd_pub_y),
    .rd_err(rd_err), .zeroize(zeroize), .busy(busy), .slot_valid(slot_valid),
    .slot_locked(slot_locked)
  );

  ecdsa_key_store #(.KEY_W(KW), .NUM_SLOTS(3), .SLOT_AW(2), .CURVE_N(CN)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready3), .ld_slot(ld_slot),
    .ld_priv(ld_priv), .ld_pub_x(ld_pub_x), .ld_pub_y(ld_pub_y), .ld_lock(ld_lock),
    .ld_done(ld_done3), .ld_err(ld_err3), .rd_req(rd_req), .rd_slot(rd_slot),
    .rd_valid(rd_valid3), .rd_priv(rd_priv3), .rd_pub_x(rd_pub_x3), .rd_pub_y(rd_pub_y3),
    .rd_err(rd_err3), .zeroize(zeroize), .busy(busy3), .slot_valid(slot_valid3),
    .slot_locked(slot_locked3)
  );

  int checks = 0;
  int errors = 0;

  // reference model of the 4-slot instance
  logic [KW-1:0] m_priv [4];
  logic [KW-1:0] m_x [4];
  logic [KW-1:0] m_y [4];
  logic [3:0]    m_valid, m_locked;

  typedef struct {
    logic          err;
    logic [KW-1:0] p;
    logic [KW-1:0] x;
    logic [KW-1:0] y;
  } rd_exp_t;

  logic [1:0] ld_q [$];
  rd_exp_t    rd_q [$];

  function automatic void model_clear();
    for (int k = 0; k < 4; k++) begin
      m_priv[k] = '0; m_x[k] = '0; m_y[k] = '0;
    end
    m_valid = '0; m_locked = '0;
  endfunction

  function automatic logic [1:0] predict_load(input logic [1:0] s, input logic [KW-1:0] p,
                                              input logic [KW-1:0] x, input logic [KW-1:0] y,
                                              input logic lk);
    if (m_locked[s]) return 2'd2;
    if (p == '0 || p >= CN) return 2'd1;
    m_priv[s] = p; m_x[s] = x; m_y[s] = y; m_valid[s] = 1'b1;
    if (lk) m_locked[s] = 1'b1;
    return 2'd0;
  endfunction

  function automatic rd_exp_t predict_read(input logic [1:0] s);
    rd_exp_t r;
    r.err = !m_valid[s];
    r.p = m_valid[s] ? m_priv[s] : '0;
    r.x = m_valid[s] ? m_x[s] : '0;
    r.y = m_valid[s] ? m_y[s] : '0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ld_ready && n < 20) begin tick(); n++; end
  endtask

  task automatic drive_load(input logic [1:0] s, input logic [KW-1:0] p, input logic [KW-1:0] x,
                            input logic [KW-1:0] y, input logic lk);
    wait_ready();
    ld_valid = 1'b1; ld_slot = s; ld_priv = p; ld_pub_x = x; ld_pub_y = y; ld_lock = lk;
    tick();
    ld_valid = 1'b0; ld_slot = 2'($urandom); ld_priv = {8{$urandom}};
    ld_pub_x = {8{$urandom}}; ld_pub_y = {8{$urandom}}; ld_lock = 1'($urandom);
  endtask

  // lat counts cycles from the handshake cycle to the cycle showing ld_done
  task automatic load(input logic [1:0] s, input logic [KW-1:0] p, input logic [KW-1:0] x,
                      input logic [KW-1:0] y, input logic lk,
                      output int lat, output logic [1:0] err, output logic done_after);
    drive_load(s, p, x, y, lk);
    lat = 1;
    while (!ld_done && lat < 20) begin tick(); lat++; end
    err = ld_err;
    tick();
    done_after = ld_done;
  endtask

  task automatic read(input logic [1:0] s, output logic v, output logic e,
                      output logic [KW-1:0] p, output logic [KW-1:0] x, output logic [KW-1:0] y);
    rd_req = 1'b1; rd_slot = s;
    tick();
    rd_req = 1'b0; rd_slot = 2'($urandom);
    v = rd_valid; e = rd_err; p = rd_priv; x = rd_pub_x; y = rd_pub_y;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; zeroize = 1'b0; ld_valid = 1'b0; ld_lock = 1'b0; rd_req = 1'b0;
    ld_slot = '0; rd_slot = '0; ld_priv = '0; ld_pub_x = '0; ld_pub_y = '0;
    model_clear();
    repeat (3) tick();
    checks++;
    if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready_in_reset got=%b exp=1", ld_ready); end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({ld_ready, busy, ld_done, ld_err, rd_valid, rd_err, slot_valid, slot_locked} !== {1'b1, 14'd0}) begin
      errors++;
      $display("FAIL reset_idle got=%b exp=%b", {ld_ready, busy, ld_done, ld_err, rd_valid, rd_err, slot_valid, slot_locked}, {1'b1, 14'd0});
    end
  endtask

  task automatic test_basic_load();
    int lat; logic [1:0] err, exp_e; logic da, v, e; logic [KW-1:0] p, x, y; rd_exp_t r;
    ld_q.push_back(predict_load(2'd1, 256'd1, KA, KB, 1'b0));
    load(2'd1, 256'd1, KA, KB, 1'b0, lat, err, da);
    exp_e = ld_q.pop_front();
    checks++;
    if (lat != 2 || err !== exp_e || da !== 1'b0) begin
      errors++; $display("FAIL basic_load got lat=%0d err=%0d done_after=%b exp lat=2 err=%0d done_after=0", lat, err, da, exp_e);
    end
    checks++;
    if (slot_valid !== 4'b0010) begin errors++; $display("FAIL basic_slot_valid got=%b exp=0010", slot_valid); end
    rd_q.push_back(predict_read(2'd1));
    read(2'd1, v, e, p, x, y);
    r = rd_q.pop_front();
    checks++;
    if ({v, e, p, x, y} !== {1'b1, r.err, r.p, r.x, r.y}) begin
      errors++; $display("FAIL basic_read got v=%b e=%b p=%0h x=%0h exp v=1 e=%b p=%0h x=%0h", v, e, p, x, r.err, r.p, r.x);
    end
    tick();
    checks++;
    if ({rd_valid, rd_err, rd_priv, rd_pub_x, rd_pub_y} !== '0) begin
      errors++; $display("FAIL read_residue got v=%b p=%0h exp v=0 p=0", rd_valid, rd_priv);
    end
  endtask

  task automatic test_range_check();
    logic [KW-1:0] tbl [3];
    int lat; logic [1:0] err, exp_e; logic da;
    tbl[0] = '0; tbl[1] = CN; tbl[2] = CN - 1;
    for (int i = 0; i < 3; i++) begin
      ld_q.push_back(predict_load(2'd0, tbl[i], KB, KA, 1'b0));
      load(2'd0, tbl[i], KB, KA, 1'b0, lat, err, da);
      exp_e = ld_q.pop_front();
      checks++;
      if (lat != 2 || err !== exp_e || slot_valid[0] !== m_valid[0]) begin
        errors++; $display("FAIL range_load%0d got lat=%0d err=%0d valid0=%b exp lat=2 err=%0d valid0=%b", i, lat, err, slot_valid[0], exp_e, m_valid[0]);
      end
    end
  endtask

  task automatic test_lock();
    int lat; logic [1:0] err, exp_e; logic da, v, e; logic [KW-1:0] p, x, y; rd_exp_t r;
    for (int i = 0; i < 2; i++) begin
      ld_q.push_back(predict_load(2'd2, (i == 0) ? KC : KD, KA, KC, 1'b1));
      load(2'd2, (i == 0) ? KC : KD, KA, KC, 1'b1, lat, err, da);
      exp_e = ld_q.pop_front();
      checks++;
      if (err !== exp_e) begin errors++; $display("FAIL lock_load%0d got err=%0d exp err=%0d", i, err, exp_e); end
    end
    rd_q.push_back(predict_read(2'd2));
    read(2'd2, v, e, p, x, y);
    r = rd_q.pop_front();
    checks++;
    if ({v, e, p, x, y} !== {1'b1, r.err, r.p, r.x, r.y}) begin
      errors++; $display("FAIL lock_read got e=%b p=%0h exp e=%b p=%0h", e, p, r.err, r.p);
    end
    checks++;
    if (slot_locked !== 4'b0100) begin errors++; $display("FAIL lock_status got=%b exp=0100", slot_locked); end
  endtask

  task automatic test_bad_index();
    int lat; logic [1:0] err, exp_e; logic da, v, e; logic [KW-1:0] p, x, y; rd_exp_t r;
    ld_q.push_back(predict_load(2'd3, KD, KC, KB, 1'b0));
    load(2'd3, KD, KC, KB, 1'b0, lat, err, da);
    exp_e = ld_q.pop_front();
    checks++;
    if (err !== exp_e || ld_err3 !== 2'd3) begin
      errors++; $display("FAIL bad_index_load got err4=%0d err3=%0d exp err4=%0d err3=3", err, ld_err3, exp_e);
    end
    rd_q.push_back(predict_read(2'd3));
    read(2'd3, v, e, p, x, y);
    r = rd_q.pop_front();
    checks++;
    if ({v, e, p} !== {1'b1, r.err, r.p} || {rd_valid3, rd_err3, rd_priv3, rd_pub_x3, rd_pub_y3} !== {2'b11, 768'd0}) begin
      errors++; $display("FAIL bad_index_read got e4=%b p4=%0h v3=%b e3=%b p3=%0h exp e4=%b p4=%0h v3=1 e3=1 p3=0", e, p, rd_valid3, rd_err3, rd_priv3, r.err, r.p);
    end
  endtask

  task automatic test_overwrite_read();
    logic [1:0] exp_e; logic v, e; logic [KW-1:0] p, x, y; rd_exp_t r;
    rd_q.push_back(predict_read(2'd1));
    ld_q.push_back(predict_load(2'd1, KC, KC, KD, 1'b0));
    drive_load(2'd1, KC, KC, KD, 1'b0);
    tick();
    exp_e = ld_q.pop_front();
    checks++;
    if (ld_done !== 1'b1 || ld_err !== exp_e) begin
      errors++; $display("FAIL overwrite_done got done=%b err=%0d exp done=1 err=%0d", ld_done, ld_err, exp_e);
    end
    read(2'd1, v, e, p, x, y);
    r = rd_q.pop_front();
    checks++;
    if ({v, e, p, x, y} !== {1'b1, r.err, r.p, r.x, r.y}) begin
      errors++; $display("FAIL read_during_write got p=%0h x=%0h exp p=%0h x=%0h", p, x, r.p, r.x);
    end
    rd_q.push_back(predict_read(2'd1));
    read(2'd1, v, e, p, x, y);
    r = rd_q.pop_front();
    checks++;
    if ({v, e, p, x, y} !== {1'b1, r.err, r.p, r.x, r.y}) begin
      errors++; $display("FAIL read_after_write got p=%0h y=%0h exp p=%0h y=%0h", p, y, r.p, r.y);
    end
  endtask

  task automatic test_zeroize();
    logic v, e; logic [KW-1:0] p, x, y; rd_exp_t r;
    checks++;
    if (slot_valid !== m_valid || m_valid !== 4'b1111) begin
      errors++; $display("FAIL zeroize_prefill got=%b exp=1111", slot_valid);
    end
    drive_load(2'd0, KA, KA, KA, 1'b0);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy !== 1'b1 || ld_done !== 1'b0 || (k > 0 && {rd_valid, rd_err, rd_priv} !== {2'b11, 256'd0})) begin
        errors++; $display("FAIL zeroize_cycle%0d got busy=%b done=%b rv=%b re=%b exp busy=1 done=0 rv=1 re=1", k, busy, ld_done, rd_valid, rd_err);
      end
      rd_req = 1'b1; rd_slot = 2'd3;
      tick();
    end
    rd_req = 1'b0;
    model_clear();
    checks++;
    if ({busy, ld_done, ld_ready, rd_valid, rd_err, slot_valid, slot_locked} !== {5'b00111, 8'd0}) begin
      errors++; $display("FAIL zeroize_end got=%b exp=%b", {busy, ld_done, ld_ready, rd_valid, rd_err, slot_valid, slot_locked}, {5'b00111, 8'd0});
    end
    rd_q.push_back(predict_read(2'd2));
    read(2'd2, v, e, p, x, y);
    r = rd_q.pop_front();
    checks++;
    if ({v, e, p} !== {1'b1, r.err, r.p}) begin
      errors++; $display("FAIL zeroize_read got e=%b p=%0h exp e=%b p=%0h", e, p, r.err, r.p);
    end
  endtask

  task automatic test_reset_mid_write();
    drive_load(2'd0, KB, KB, KB, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({ld_ready, ld_done, ld_err, busy, rd_valid, rd_err, slot_valid, slot_locked, rd_priv} !== {1'b1, 270'd0}) begin
      errors++; $display("FAIL reset_mid_write got ready=%b done=%b busy=%b valid=%b locked=%b exp ready=1 rest 0", ld_ready, ld_done, busy, slot_valid, slot_locked);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({ld_ready, busy, slot_valid, slot_locked} !== {1'b1, 1'b0, m_valid, m_locked}) begin
      errors++; $display("FAIL reset_release got ready=%b busy=%b valid=%b exp ready=1 busy=0 valid=%b", ld_ready, busy, slot_valid, m_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_range_check();
    test_lock();
    test_bad_index();
    test_overwrite_read();
    test_zeroize();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
